// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] HALT_INST = 32'hFFFF_FFFF;
    localparam logic [ADDR_W-1:0] PC_STEP   = 32'd4;

    // One queued fetch: the instruction word and the address of the next one.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pcplus4;
    } fetch_entry_t;

    // Byte address with the low two bits cleared (instructions are word aligned).
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush that wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_wdata,
    output fetch_entry_t             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    // A full FIFO accepts a push only when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    // Entry storage: written on accepted pushes only.
    // NOTE: the storage array has no reset; entries beyond the valid count are never observed.
    always_ff @(posedge CLK) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and count bookkeeping; flush behaves like a reset.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, detects the halt word and arbitrates
// redirects against sequential fetch pushes into a small FIFO.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic [ADDR_W-1:0]      fetch_addr,
    input  logic [INST_W-1:0]      imem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INST_W-1:0]      out_inst,
    output logic [ADDR_W-1:0]      out_pcplus4,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] occupancy
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_halted;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic [ADDR_W-1:0] w_pcplus4;
    fetch_entry_t      w_wdata;
    fetch_entry_t      w_head;

    assign w_pcplus4  = r_pc + PC_STEP;
    assign w_wdata    = '{inst: imem_data, pcplus4: w_pcplus4};
    assign fetch_addr = r_pc >> 2;
    assign out_valid  = ~w_empty;
    assign halted     = r_halted;

    assign w_pop  = out_valid & out_ready;
    assign w_push = ENABLE & ~r_halted & ~redirect_valid & (~w_full | w_pop);

    fetch_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy)
    );

    // Head presentation: zeros when the queue is empty so stale entries never leak.
    // NOTE: outputs get defaults first so no path leaves them unassigned (no latch).
    always_comb begin
        out_inst    = '0;
        out_pcplus4 = '0;
        if (!w_empty) begin
            out_inst    = w_head.inst;
            out_pcplus4 = w_head.pcplus4;
        end
    end

    // PC and halt state: reset, then redirect, then sequential advance on push.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= align_word(redirect_pc);
            r_halted <= 1'b0;
        end else if (w_push) begin
            r_pc <= w_pcplus4;
            // The halt word itself is queued; fetching stops after it.
            if (imem_data == HALT_INST) begin
                r_halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a behavioural model predicts pushes,
// queues the expected entries and compares them as the head is presented.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] fetch_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pcplus4;
    logic        halted;
    logic [$clog2(DEPTH):0] occupancy;

    // Instruction memory stand-in.
    logic        tag_mode = 1'b0;
    logic        halt_en  = 1'b0;
    logic [31:0] halt_addr = '0;

    assign imem_data = (halt_en && fetch_addr == halt_addr) ? 32'hFFFF_FFFF :
                       (tag_mode ? {16'h2008, fetch_addr[15:0]} : 32'h2008_0005);

    fetch_queue #(
        .DEPTH          (DEPTH),
        .RESET_PC       (RESET_PC)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ENABLE         (ENABLE),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_addr     (fetch_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pcplus4    (out_pcplus4),
        .halted         (halted),
        .occupancy      (occupancy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model state and scoreboard of expected queue contents.
    fetch_entry_t sb[$];
    logic [31:0]  m_pc = RESET_PC;
    logic         m_halted = 1'b0;
    logic         m_prev_redir = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Synchronous reset pulse from a known point; model restarts with it.
    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        sb.delete();
        m_pc = RESET_PC;
        m_halted = 1'b0;
        m_prev_redir = 1'b0;
    endtask

    // One clock: compare DUT against the model, advance the model, step the clock.
    // Called at a falling edge with inputs already applied.
    task automatic cycle();
        fetch_entry_t e;
        logic do_pop;
        logic do_push;
        #1;
        check("occ_le_depth", 32'(occupancy <= DEPTH), 32'd1);
        if (m_prev_redir) check("valid_after_redirect", 32'(out_valid), 32'd0);
        check("fetch_addr", fetch_addr, m_pc >> 2);
        check("halted", 32'(halted), 32'(m_halted));
        check("occupancy", 32'(occupancy), 32'(sb.size()));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("head_inst", out_inst, sb[0].inst);
            check("head_pcplus4", out_pcplus4, sb[0].pcplus4);
        end else begin
            check("empty_inst", out_inst, 32'd0);
            check("empty_pcplus4", out_pcplus4, 32'd0);
        end
        m_prev_redir = redirect_valid;
        if (RESET) begin
            sb.delete();
            m_pc = RESET_PC;
            m_halted = 1'b0;
        end else if (redirect_valid) begin
            sb.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            m_halted = 1'b0;
        end else begin
            do_pop  = (sb.size() != 0) && out_ready;
            do_push = ENABLE && !m_halted && ((sb.size() < DEPTH) || do_pop);
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                e.inst    = imem_data;
                e.pcplus4 = m_pc + 32'd4;
                sb.push_back(e);
                if (imem_data == 32'hFFFF_FFFF) m_halted = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic found;

        // Reset state.
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_pcplus4", out_pcplus4, 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_fetch_addr", fetch_addr, RESET_PC >> 2);
        check("rst_halted", 32'(halted), 32'd0);

        // Streaming: one push and one pop per cycle.
        ENABLE = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("stream_first_valid", 32'(out_valid), 32'd1);
        check("stream_first_pc4", out_pcplus4, 32'd4);
        check("stream_first_inst", out_inst, 32'h2008_0005);
        cycle();
        check("stream_second_pc4", out_pcplus4, 32'd8);
        check("stream_occ", 32'(occupancy), 32'd1);
        cycle();
        check("stream_third_pc4", out_pcplus4, 32'd12);
        check("stream_occ2", 32'(occupancy), 32'd1);

        // Back-pressure fills the queue, then it drains in order.
        tag_mode = 1'b1;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        check("stall_full_occ", 32'(occupancy), 32'd4);
        check("stall_pc_hold", fetch_addr, 32'd16 >> 2);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("drain_order_pc4", out_pcplus4, 32'(4 * (k + 1)));
            cycle();
        end

        // Redirect from a full queue with a pop pending.
        check("pre_redirect_full", 32'(occupancy), 32'd4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        cycle();
        redirect_valid = 1'b0;
        check("redir_occ", 32'(occupancy), 32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_fetch_addr", fetch_addr, 32'h10);
        cycle();
        check("redir_head_valid", 32'(out_valid), 32'd1);
        check("redir_head_pc4", out_pcplus4, 32'h44);

        // Halt word at pc=12.
        halt_en = 1'b1;
        halt_addr = 32'd3;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("halt_set", 32'(halted), 32'd1);
        check("halt_pc_hold", fetch_addr, 32'd4);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (out_valid && out_inst == 32'hFFFF_FFFF) found = 1'b1;
            else cycle();
        end
        check("halt_word_seen", 32'(found), 32'd1);
        check("halt_word_pc4", out_pcplus4, 32'd16);
        for (int i = 0; i < 3; i++) cycle();
        check("halt_drained", 32'(occupancy), 32'd0);
        check("halt_still_hold", fetch_addr, 32'd4);
        check("halt_still_set", 32'(halted), 32'd1);
        halt_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        cycle();
        redirect_valid = 1'b0;
        check("halt_cleared", 32'(halted), 32'd0);
        cycle();
        check("resume_valid", 32'(out_valid), 32'd1);
        check("resume_pc4", out_pcplus4, 32'd4);

        // Reset overrides push, pop and redirect in the same cycle.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("pre_reset_occ", 32'(occupancy), 32'd3);
        RESET = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        RESET = 1'b0;
        redirect_valid = 1'b0;
        check("midrst_occ", 32'(occupancy), 32'd0);
        check("midrst_pc", fetch_addr, RESET_PC >> 2);
        check("midrst_halted", 32'(halted), 32'd0);
        check("midrst_inst", out_inst, 32'd0);

        // ENABLE low: the queue drains while the PC holds.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) cycle();
        check("pre_disable_occ", 32'(occupancy), 32'd2);
        ENABLE = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("disable_occ1", 32'(occupancy), 32'd1);
        check("disable_addr1", fetch_addr, 32'd2);
        cycle();
        check("disable_occ0", 32'(occupancy), 32'd0);
        check("disable_addr0", fetch_addr, 32'd2);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
